// File: rtl/imem_arb_pkg.sv
// imem_arb_pkg: shared types and helpers for the instruction-memory port arbiter
package imem_arb_pkg;
  typedef enum logic [1:0] {RUN, LOCKED, DRAIN} state_e;
  typedef enum logic [1:0] {NONE, IF, LD} owner_e;
  localparam int STREAK_W = 4;
  function automatic int word_addr_w(input int addr_w);
    return addr_w - 2;
  endfunction
endpackage

// File: rtl/imem_port_arbiter_if.sv
// imem_port_arbiter_if: fetch, loader and memory-side signals of the IMEM arbiter
interface imem_port_arbiter_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  import imem_arb_pkg::*;
  logic                          if_req;
  logic [ADDR_W-1:0]             if_addr;
  logic                          if_gnt;
  logic                          if_stall;
  logic                          if_rvalid;
  logic [DATA_W-1:0]             if_rdata;
  logic                          ld_req;
  logic                          ld_we;
  logic                          ld_lock;
  logic [ADDR_W-1:0]             ld_addr;
  logic [DATA_W-1:0]             ld_wdata;
  logic                          ld_gnt;
  logic                          ld_rvalid;
  logic [DATA_W-1:0]             ld_rdata;
  logic                          locked;
  logic                          addr_err;
  logic                          mem_en;
  logic                          mem_we;
  logic [word_addr_w(ADDR_W)-1:0] mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;
  modport slave (
    input  if_req, if_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    output if_gnt, if_stall, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
           locked, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, ld_req, ld_we, ld_lock, ld_addr, ld_wdata, mem_rdata,
    input  if_gnt, if_stall, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata,
           locked, addr_err, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_starve_cnt.sv
// imem_starve_cnt: saturating count of loader wins while fetch waits; clr beats freeze beats inc
module imem_starve_cnt import imem_arb_pkg::*; #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  input  logic freeze,
  output logic at_max
);
  logic [STREAK_W-1:0] streak_q, streak_d;
  assign at_max = streak_q >= STREAK_W'(MAX);
  always_comb streak_d = clr ? '0 : (freeze | ~inc | at_max) ? streak_q : streak_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) streak_q <= '0;
    else streak_q <= streak_d;
endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the single-port IMEM between IF fetch and the loader/debug port.
// Define IMEM_ALIGN_CHK_EN to suppress misaligned granted accesses and flag them on addr_err.
module imem_port_arbiter import imem_arb_pkg::*; #(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  imem_port_arbiter_if.slave  bus
);
  state_e            state_q, state_d;
  owner_e            rd_owner_q, rd_owner_d;
  logic              addr_err_q, addr_err_d;
  logic              run, at_max, gnt, misalign;
  logic [ADDR_W-1:0] gnt_addr;

  assign run          = state_q == RUN;
  assign bus.if_gnt   = run & bus.if_req & (~bus.ld_req | at_max);
  assign bus.ld_gnt   = bus.ld_req & (state_q != DRAIN) & ~bus.if_gnt;
  assign bus.if_stall = bus.if_req & ~bus.if_gnt;
  assign gnt          = bus.if_gnt | bus.ld_gnt;
  assign gnt_addr     = bus.ld_gnt ? bus.ld_addr : bus.if_addr;

`ifdef IMEM_ALIGN_CHK_EN
  assign misalign = gnt & (gnt_addr[1:0] != 2'b00);
`else
  logic unused_lo;
  assign unused_lo = ^gnt_addr[1:0];
  assign misalign  = 1'b0;
`endif

  assign bus.mem_en    = gnt & ~misalign;
  assign bus.mem_we    = bus.ld_gnt & bus.ld_we & ~misalign;
  assign bus.mem_addr  = gnt_addr[ADDR_W-1:2];
  assign bus.mem_wdata = bus.ld_wdata;
  assign bus.if_rvalid = rd_owner_q == IF;
  assign bus.ld_rvalid = rd_owner_q == LD;
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.ld_rdata  = bus.ld_rvalid ? bus.mem_rdata : '0;
  assign bus.locked    = state_q == LOCKED;
  assign bus.addr_err  = addr_err_q;

  always_comb begin
    state_d    = bus.ld_lock ? LOCKED : (state_q == LOCKED ? DRAIN : RUN);
    rd_owner_d = (bus.mem_en & ~bus.mem_we) ? (bus.ld_gnt ? LD : IF) : NONE;
    addr_err_d = misalign;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= RUN;
      rd_owner_q <= NONE;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_owner_q <= rd_owner_d;
      addr_err_q <= addr_err_d;
    end

  // Streak sits at 0 while locked and holds through the drain cycle
  imem_starve_cnt #(.MAX(STARVE_MAX)) u_starve (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc    (run & bus.ld_gnt & bus.if_req),
    .clr    ((state_q == LOCKED) | (run & (~bus.if_req | bus.if_gnt))),
    .freeze (state_q == DRAIN),
    .at_max (at_max)
  );
endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: randomized and directed checks of imem_port_arbiter against a cycle model
module tb_imem_port_arbiter;
  localparam int AW = 7, DW = 32, SM = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  imem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [32];
  initial for (int i = 0; i < 32; i++) mem[i] = i;
  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end

  // Reference model: mode 0=run 1=locked 2=drain, m_wait = loader wins while fetch waited
  int            m_mode, m_wait, m_pend;
  logic [DW-1:0] m_pdata;
  logic          m_aerr;
  logic [DW-1:0] ref_mem [32];
  logic          e_ig, e_lg, e_en, e_we, e_mis;
  logic [8:0]    e_ctl;
  logic [4:0]    e_wa;
  logic [DW-1:0] e_ird, e_lrd;
  int            vec = 0, bad = 0;

  function automatic logic [8:0] obs();
    return {bus.if_gnt, bus.ld_gnt, bus.if_stall, bus.mem_en, bus.mem_we,
            bus.if_rvalid, bus.ld_rvalid, bus.locked, bus.addr_err};
  endfunction

  function automatic logic [AW-1:0] raddr();
    logic [AW-1:0] a;
    a = {5'($urandom_range(0, 31)), 2'b00};
    if ($urandom_range(0, 3) == 0) a[1:0] = 2'($urandom_range(1, 3));
    return a;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_pend = 0; m_pdata = '0; m_aerr = 1'b0;
  endtask

  task automatic drive(input logic ifr, input logic [AW-1:0] ifa, input logic ldr,
                       input logic we, input logic lk, input logic [AW-1:0] lda,
                       input logic [DW-1:0] wd);
    bus.if_req = ifr; bus.if_addr = ifa; bus.ld_req = ldr; bus.ld_we = we;
    bus.ld_lock = lk; bus.ld_addr = lda; bus.ld_wdata = wd;
  endtask

  task automatic predict();
    logic [AW-1:0] a;
    #1;
    e_ig = bus.if_req && m_mode == 0 && (!bus.ld_req || m_wait == SM);
    e_lg = bus.ld_req && m_mode != 2 && !e_ig;
    a = e_lg ? bus.ld_addr : bus.if_addr;
`ifdef IMEM_ALIGN_CHK_EN
    e_mis = (e_ig || e_lg) && (a % 4 != 0);
`else
    e_mis = 1'b0;
`endif
    e_en  = (e_ig || e_lg) && !e_mis;
    e_we  = e_en && e_lg && bus.ld_we;
    e_wa  = 5'(a / 4);
    e_ird = (m_pend == 1) ? m_pdata : '0;
    e_lrd = (m_pend == 2) ? m_pdata : '0;
    e_ctl = {e_ig, e_lg, bus.if_req && !e_ig, e_en, e_we,
             m_pend == 1, m_pend == 2, m_mode == 1, m_aerr};
  endtask

  task automatic advance();
    @(posedge clk);
    m_pend = (e_en && !e_we) ? (e_lg ? 2 : 1) : 0;
    if (m_pend != 0) m_pdata = ref_mem[e_wa];
    if (e_we) ref_mem[e_wa] = bus.ld_wdata;
    m_aerr = e_mis;
    if (m_mode == 0) m_wait = (bus.if_req && e_lg) ? m_wait + 1 : 0;
    else if (m_mode == 1) m_wait = 0;
    if (m_mode == 1) m_mode = bus.ld_lock ? 1 : 2;
    else m_mode = bus.ld_lock ? 1 : 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    model_reset();
    @(negedge clk);
    predict();
    vec++;
    if (obs() !== 9'b0 || bus.if_rdata !== '0 || bus.ld_rdata !== '0) begin
      bad++;
      $display("FAIL reset: ctl=%b rd=%h/%h, want ctl=000000000 rd=0/0", obs(), bus.if_rdata, bus.ld_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch_seq();
    for (int i = 0; i < 4; i++) begin
      drive(i < 3, 7'(i * 4), 0, 0, 0, 0, 0);
      predict();
      vec++;
      if (obs() !== e_ctl || bus.if_rdata !== e_ird || bus.ld_rdata !== e_lrd || (e_en && bus.mem_addr !== e_wa)) begin
        bad++;
        $display("FAIL fetch_seq %0d: ctl=%b ird=%h addr=%h want ctl=%b ird=%h addr=%h", i, obs(), bus.if_rdata, bus.mem_addr, e_ctl, e_ird, e_wa);
      end
      vec++;
      if (i > 0 && bus.if_rdata !== DW'(i - 1)) begin
        bad++;
        $display("FAIL fetch_word %0d: got %h want %h", i, bus.if_rdata, i - 1);
      end
      advance();
    end
  endtask

  task automatic test_starvation();
    logic [AW-1:0] ifa = 7'h08, lda = 7'h40;
    int stalls = 0;
    for (int i = 0; i < 15; i++) begin
      drive(1, ifa, 1, 0, 0, lda, 0);
      predict();
      vec++;
      if (obs() !== e_ctl || bus.if_rdata !== e_ird || bus.ld_rdata !== e_lrd || (e_en && bus.mem_addr !== e_wa)) begin
        bad++;
        $display("FAIL starve %0d: ctl=%b rd=%h/%h want ctl=%b rd=%h/%h", i, obs(), bus.if_rdata, bus.ld_rdata, e_ctl, e_ird, e_lrd);
      end
      vec++;
      if (bus.ld_gnt !== (i % 5 != 4)) begin
        bad++;
        $display("FAIL starve_pattern %0d: ld_gnt=%b want %b", i, bus.ld_gnt, i % 5 != 4);
      end
      stalls += int'(bus.if_stall);
      if (e_ig) ifa = {5'($urandom_range(0, 31)), 2'b00};
      if (e_lg) lda = {5'($urandom_range(0, 31)), 2'b00};
      advance();
    end
    vec++;
    if (stalls != 12) begin
      bad++;
      $display("FAIL starve_stalls: got %0d stall cycles want 12", stalls);
    end
  endtask

  typedef struct packed {
    logic ifr; logic [AW-1:0] ifa; logic ldr; logic we; logic lk; logic [AW-1:0] lda; logic [DW-1:0] wd;
  } row_t;

  task automatic test_lock_drain();
    row_t rows [14];
    rows = '{
      '{1'b1, 7'h10, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b1, 7'h14, 1'b0, 1'b0, 1'b1, 7'h00, 32'h0},
      '{1'b1, 7'h18, 1'b1, 1'b1, 1'b1, 7'h00, 32'h20080020},
      '{1'b1, 7'h18, 1'b1, 1'b0, 1'b1, 7'h00, 32'h0},
      '{1'b1, 7'h18, 1'b1, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b1, 7'h18, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b1, 7'h18, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b0, 7'h00, 1'b0, 1'b0, 1'b1, 7'h00, 32'h0},
      '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b1, 7'h1c, 1'b0, 1'b0, 1'b1, 7'h00, 32'h0},
      '{1'b1, 7'h1c, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b1, 7'h1c, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b1, 7'h1c, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0},
      '{1'b0, 7'h00, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0}
    };
    for (int i = 0; i < 14; i++) begin
      drive(rows[i].ifr, rows[i].ifa, rows[i].ldr, rows[i].we, rows[i].lk, rows[i].lda, rows[i].wd);
      predict();
      vec++;
      if (obs() !== e_ctl || bus.if_rdata !== e_ird || bus.ld_rdata !== e_lrd || (e_en && bus.mem_addr !== e_wa) || (e_we && bus.mem_wdata !== bus.ld_wdata)) begin
        bad++;
        $display("FAIL lock_drain %0d: ctl=%b rd=%h/%h want ctl=%b rd=%h/%h", i, obs(), bus.if_rdata, bus.ld_rdata, e_ctl, e_ird, e_lrd);
      end
      vec++;
      if ((i == 2 && (bus.locked !== 1'b1 || bus.if_rvalid !== 1'b1)) || (i == 4 && bus.ld_rdata !== 32'h20080020) ||
          (i == 5 && (bus.ld_rvalid !== 1'b1 || bus.mem_en !== 1'b0)) || (i == 6 && bus.if_gnt !== 1'b1) ||
          (i == 10 && bus.locked !== 1'b1)) begin
        bad++;
        $display("FAIL lock_point %0d: locked=%b if_rv=%b ld_rv=%b ld_rd=%h mem_en=%b if_gnt=%b", i, bus.locked, bus.if_rvalid, bus.ld_rvalid, bus.ld_rdata, bus.mem_en, bus.if_gnt);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 7'h04, 1, 0, i == 2, 7'(8 + 4 * i), 0);
      predict();
      vec++;
      if (obs() !== e_ctl || bus.ld_rdata !== e_lrd || bus.if_rdata !== e_ird) begin
        bad++;
        $display("FAIL pre_reset %0d: ctl=%b want %b", i, obs(), e_ctl);
      end
      advance();
    end
    #1 rst_n = 1'b0;
    #1;
    vec++;
    if (bus.ld_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0 || bus.locked !== 1'b0 || bus.ld_rdata !== '0) begin
      bad++;
      $display("FAIL async_reset: ld_rv=%b if_rv=%b locked=%b ld_rd=%h want 0", bus.ld_rvalid, bus.if_rvalid, bus.locked, bus.ld_rdata);
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1, 7'h0c, 1, 0, 0, 7'(4 * i), 0);
      predict();
      vec++;
      if (obs() !== e_ctl || bus.ld_rdata !== e_lrd || bus.if_rdata !== e_ird) begin
        bad++;
        $display("FAIL post_reset %0d: ctl=%b rd=%h/%h want ctl=%b rd=%h/%h", i, obs(), bus.if_rdata, bus.ld_rdata, e_ctl, e_ird, e_lrd);
      end
      advance();
    end
  endtask

  task automatic test_align();
    drive(1, 7'h06, 0, 0, 0, 0, 0);
    predict();
    vec++;
`ifdef IMEM_ALIGN_CHK_EN
    if (bus.if_gnt !== 1'b1 || bus.mem_en !== 1'b0 || obs() !== e_ctl) begin
`else
    if (bus.if_gnt !== 1'b1 || bus.mem_en !== 1'b1 || bus.mem_addr !== 5'd1 || obs() !== e_ctl) begin
`endif
      bad++;
      $display("FAIL align_gnt: if_gnt=%b mem_en=%b addr=%h ctl=%b want ctl=%b", bus.if_gnt, bus.mem_en, bus.mem_addr, obs(), e_ctl);
    end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    predict();
    vec++;
`ifdef IMEM_ALIGN_CHK_EN
    if (bus.addr_err !== 1'b1 || bus.if_rvalid !== 1'b0 || obs() !== e_ctl) begin
`else
    if (bus.addr_err !== 1'b0 || bus.if_rvalid !== 1'b1 || bus.if_rdata !== e_ird || obs() !== e_ctl) begin
`endif
      bad++;
      $display("FAIL align_next: addr_err=%b if_rv=%b ird=%h ctl=%b want ctl=%b", bus.addr_err, bus.if_rvalid, bus.if_rdata, obs(), e_ctl);
    end
    advance();
  endtask

  task automatic test_random();
    logic ifr = 0, ldr = 0, we = 0, lk = 0, gi, gl;
    logic [AW-1:0] ifa = 0, lda = 0;
    logic [DW-1:0] wd = 0;
    for (int c = 0; c < 400; c++) begin
      if (!ifr) begin ifr = $urandom_range(0, 2) != 0; ifa = raddr(); end
      if (!ldr) begin ldr = 1'($urandom_range(0, 1)); we = 1'($urandom_range(0, 1)); lda = raddr(); wd = $urandom; end
      if ($urandom_range(0, 7) == 0) lk = ~lk;
      drive(ifr, ifa, ldr, we, lk, lda, wd);
      predict();
      vec++;
      if (obs() !== e_ctl || bus.if_rdata !== e_ird || bus.ld_rdata !== e_lrd || (e_en && bus.mem_addr !== e_wa) || (e_we && bus.mem_wdata !== wd)) begin
        bad++;
        $display("FAIL random %0d: ctl=%b rd=%h/%h addr=%h want ctl=%b rd=%h/%h addr=%h", c, obs(), bus.if_rdata, bus.ld_rdata, bus.mem_addr, e_ctl, e_ird, e_lrd, e_wa);
      end
      gi = e_ig; gl = e_lg;
      advance();
      if (gi) ifr = 1'b0;
      if (gl) ldr = 1'b0;
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ref_mem[i] = i;
    test_reset();
    test_fetch_seq();
    test_starvation();
    test_lock_drain();
    test_async_reset();
    test_align();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
